// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding and the
// clocks-per-bit helper used to size baud counters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop Rx synchroniser plus mid-bit
// sampling FSM. Ports: clk, rst, rx (async), data (last good byte).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CPB = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data
);

  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);

  logic [1:0]    sync;
  logic          rs;
  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    data_n;

  assign rs = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      st   <= IDLE;
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      data <= '0;
    end else begin
      sync <= {sync[0], rx};
      st   <= st_n;
      cnt  <= cnt_n;
      idx  <= idx_n;
      sh   <= sh_n;
      data <= data_n;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    idx_n  = idx;
    sh_n   = sh;
    data_n = data;
    unique case (st)
      IDLE: begin
        if (!rs) begin
          st_n  = START;
          cnt_n = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          idx_n = '0;
          // high at mid-start: treat as glitch
          st_n  = rs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {rs, sh[7:1]};
          if (idx == 3'd7) st_n = STOP;
          else idx_n = idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          st_n  = IDLE;
          if (rs) data_n = sh;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART top: inline transmit FSM plus uart_rx.
// Ports: clk, rst, data_in, wr_en (active low), Tx, Rx, Tx_busy, data_out.
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       Tx,
  input  logic       Rx,
  output logic       Tx_busy,
  output logic [7:0] data_out
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          tx_n, busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      Tx      <= 1'b1;
      Tx_busy <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      Tx      <= tx_n;
      Tx_busy <= busy_n;
    end
  end

  // sh shifts right so sh[1] is always the next data bit
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    idx_n  = idx;
    sh_n   = sh;
    tx_n   = Tx;
    busy_n = Tx_busy;
    unique case (st)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (!wr_en) begin
          st_n   = START;
          cnt_n  = '0;
          sh_n   = data_in;
          tx_n   = 1'b0;
          busy_n = 1'b1;
        end
      end
      START: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          idx_n = '0;
          st_n  = DATA;
          tx_n  = sh[0];
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {1'b0, sh[7:1]};
          if (idx == 3'd7) begin
            st_n = STOP;
            tx_n = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = sh[1];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n  = '0;
          st_n   = IDLE;
          busy_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

  uart_rx #(
    .CPB(CPB)
  ) u_rx (
    .clk (clk),
    .rst (rst),
    .rx  (Rx),
    .data(data_out)
  );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart at 10 clocks per bit.
// Expected line values come from an 8N1 frame model.
module tb_uart;

  logic       clk    = 1'b0;
  logic       clk_on = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       Tx;
  logic       Rx;
  logic       Tx_busy;
  logic [7:0] data_out;
  logic       loop;
  logic       rx_drv;
  logic [7:0] rx_model;
  logic [7:0] d;
  int         checks   = 0;
  int         failures = 0;

  assign Rx = loop ? Tx : rx_drv;

  uart #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .wr_en   (wr_en),
    .Tx      (Tx),
    .Rx      (Rx),
    .Tx_busy (Tx_busy),
    .data_out(data_out)
  );

  initial begin
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // line level k cycles after the start bit begins
  function automatic logic line_bit(input logic [7:0] b, input int k);
    if (k < 10) return 1'b0;
    if (k < 90) return b[(k - 10) / 10];
    return 1'b1;
  endfunction

  // call right after the acceptance edge
  task automatic frame(input logic [7:0] b, input bit rx_chk);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k < 100) begin
        chk1("tx_bit", Tx, line_bit(b, k));
        chk1("tx_busy", Tx_busy, 1'b1);
      end else begin
        chk1("tx_idle", Tx, 1'b1);
        chk1("busy_drop", Tx_busy, 1'b0);
      end
      if (rx_chk && k == 85 && rx_model !== b)
        chk8("rx_early", data_out, rx_model);
      if (rx_chk && k == 100) begin
        rx_model = b;
        chk8("rx_loop", data_out, rx_model);
      end
    end
  endtask

  task automatic request(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    wr_en   = 1'b0;
    @(posedge clk);
    #1 wr_en = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_drv = (i == 0) ? 1'b0 : (i == 9) ? stopb : b[i-1];
      repeat (10) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b1;
    data_in  = 8'h00;
    loop     = 1'b0;
    rx_drv   = 1'b1;
    rx_model = 8'h00;

    // reset with clock stopped
    #2;
    chk1("rst_tx", Tx, 1'b1);
    chk1("rst_busy", Tx_busy, 1'b0);
    chk8("rst_data", data_out, 8'h00);
    clk_on = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk1("idle_tx", Tx, 1'b1);
    chk1("idle_busy", Tx_busy, 1'b0);

    // single frame
    request(8'hA5);
    frame(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    chk1("hold_tx", Tx, 1'b1);
    chk1("hold_busy", Tx_busy, 1'b0);

    // back-to-back with wr_en held low
    @(negedge clk);
    data_in = 8'h00;
    wr_en   = 1'b0;
    @(posedge clk);
    frame(8'h00, 1'b0);
    data_in = 8'h01;
    @(posedge clk);
    #1 wr_en = 1'b1;
    frame(8'h01, 1'b0);
    repeat (15) @(negedge clk);
    chk1("b2b_end_tx", Tx, 1'b1);
    chk1("b2b_end_busy", Tx_busy, 1'b0);

    // loopback
    loop = 1'b1;
    request(8'h3C);
    frame(8'h3C, 1'b1);
    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom);
      request(d);
      frame(d, 1'b1);
    end
    repeat (5) @(negedge clk);
    loop = 1'b0;

    // direct rx: good frame, framing error, glitch
    d = 8'($urandom);
    if (d == 8'h5A) d = 8'hA5;
    rx_frame(d, 1'b1);
    rx_model = d;
    chk8("rx_direct", data_out, rx_model);
    rx_frame(8'h5A, 1'b0);
    chk8("rx_framing", data_out, rx_model);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk8("rx_glitch", data_out, rx_model);
    d = 8'($urandom);
    rx_frame(d, 1'b1);
    rx_model = d;
    chk8("rx_rearm", data_out, rx_model);

    // reset in the middle of data bit 4
    d = 8'($urandom) & 8'hEF;
    request(d);
    repeat (56) @(negedge clk);
    chk1("pre_rst_tx", Tx, line_bit(d, 55));
    chk1("pre_rst_busy", Tx_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_tx", Tx, 1'b1);
    chk1("mid_rst_busy", Tx_busy, 1'b0);
    chk8("mid_rst_data", data_out, 8'h00);
    rx_model = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    d = 8'($urandom);
    request(d);
    frame(d, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
